// File: rtl/dump_fifo_if.sv
// Push/pop, error-clear and dump-port signals of dump_fifo, bundled with
// master (client) and slave (FIFO) views.
interface dump_fifo_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LGFLEN = 5
);
  logic              i_wr;
  logic [DW-1:0]     i_data;
  logic              i_rd;
  logic              i_clr_err;
  logic [LGFLEN-1:0] i_dmp_pos;
  logic [DW-1:0]     o_data;
  logic              o_empty_n;
  logic              o_full;
  logic              o_afull;
  logic [LGFLEN:0]   o_fill;
  logic              o_ovf;
  logic              o_unf;
  logic [DW-1:0]     o_dmp_data;
  logic              o_dmp_valid;

  modport master (
    output i_wr, i_data, i_rd, i_clr_err, i_dmp_pos,
    input  o_data, o_empty_n, o_full, o_afull, o_fill, o_ovf, o_unf, o_dmp_data, o_dmp_valid
  );

  modport slave (
    input  i_wr, i_data, i_rd, i_clr_err, i_dmp_pos,
    output o_data, o_empty_n, o_full, o_afull, o_fill, o_ovf, o_unf, o_dmp_data, o_dmp_valid
  );
endinterface

// File: rtl/dump_fifo.sv
// Single-clock FIFO with explicit fill counter, almost-full flag, sticky
// overflow/underflow flags and a registered position-addressed dump port.
module dump_fifo #(
  parameter int unsigned DW       = 8,
  parameter int unsigned LGFLEN   = 5,
  parameter int unsigned AF_LEVEL = (1 << LGFLEN) - 4
) (
  input logic        clk,
  input logic        reset_n,
  dump_fifo_if.slave bus
);
  localparam int unsigned N = 1 << LGFLEN;

  logic [DW-1:0]     mem [N];
  logic [LGFLEN-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [DW-1:0]     dmp_data_q, dmp_data_d;
  logic              dmp_valid_q, dmp_valid_d;
  logic              full, empty_n, push, pop;
  logic [LGFLEN-1:0] dmp_idx;

  always_comb begin
    full    = (fill_q == (LGFLEN+1)'(N));
    empty_n = (fill_q != '0);
    // At full a same-cycle pop frees the slot, so the push still goes in.
    push    = reset_n && bus.i_wr && (!full || bus.i_rd);
    pop     = bus.i_rd && empty_n;

    wp_d   = push ? wp_q + (LGFLEN)'(1) : wp_q;
    rp_d   = pop ? rp_q + (LGFLEN)'(1) : rp_q;
    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + (LGFLEN+1)'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - (LGFLEN+1)'(1);
    end

    // A new error in the clearing cycle wins over the clear.
    ovf_d = (bus.i_wr && full && !bus.i_rd) || (ovf_q && !bus.i_clr_err);
    unf_d = (bus.i_rd && !empty_n) || (unf_q && !bus.i_clr_err);

    dmp_idx     = rp_q + bus.i_dmp_pos;
    dmp_valid_d = ({1'b0, bus.i_dmp_pos} < fill_q);
    dmp_data_d  = dmp_valid_d ? mem[dmp_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q        <= '0;
      rp_q        <= '0;
      fill_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      dmp_data_q  <= '0;
      dmp_valid_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      fill_q      <= fill_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      dmp_data_q  <= dmp_data_d;
      dmp_valid_q <= dmp_valid_d;
    end
  end

  // Storage is intentionally not reset; reads are masked by fill.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_q] <= bus.i_data;
    end
  end

  always_comb begin
    bus.o_data      = empty_n ? mem[rp_q] : '0;
    bus.o_empty_n   = empty_n;
    bus.o_full      = full;
    bus.o_afull     = (fill_q >= (LGFLEN+1)'(AF_LEVEL));
    bus.o_fill      = fill_q;
    bus.o_ovf       = ovf_q;
    bus.o_unf       = unf_q;
    bus.o_dmp_data  = dmp_data_q;
    bus.o_dmp_valid = dmp_valid_q;
  end
endmodule
